// File: rtl/sha_pkg.sv
// Shared constants, state encoding and word record for the SHA-256 feeder blocks.
package sha_pkg;

   localparam int WORD_W         = 64;
   localparam int BYTE_W         = 8;
   localparam int BYTES_PER_WORD = 8;
   localparam int INV_W          = 6;
   localparam int LANE_W         = 4;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } msg_state_e;

   typedef struct packed {
      logic              last;
      logic [INV_W-1:0]  inv;
      logic [WORD_W-1:0] data;
   } word_t;

   // Invalid trailing bits for a word holding n valid bytes; n=8 wraps to 0.
   function automatic logic [INV_W-1:0] inv_bits(input logic [LANE_W-1:0] n);
      return INV_W'((BYTES_PER_WORD - int'(n)) * BYTE_W);
   endfunction

endpackage

// File: rtl/sha_word_slot.sv
// One-entry valid/ready holding register; the payload stays stable until it is taken.
module sha_word_slot #(
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_load,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_ready,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_data,
   output logic              o_can_load
);

   logic              r_valid;
   logic [DATA_W-1:0] r_data;

   // Free now, or emptying at this edge so a new entry can replace it.
   assign o_can_load = !r_valid || i_ready;

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
      end else if (r_valid && i_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;

endmodule

// File: rtl/sha_msg_packer.sv
// Packs a byte stream big-endian into 64-bit words for the SHA-256 core, with
// message framing (last word, invalid bits) and a per-message word counter.
module sha_msg_packer
   import sha_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [BYTE_W-1:0] s_byte,
   input  logic              s_valid,
   input  logic              s_last,
   output logic              s_ready,
   output logic [WORD_W-1:0] data_in,
   output logic              data_valid,
   input  logic              ready_rcv,
   output logic              ready_send,
   output logic              last_block,
   output logic [INV_W-1:0]  last_block_invalid_bits,
   output logic [CNT_W-1:0]  msg_words
);

   msg_state_e        r_state;
   msg_state_e        w_state_nxt;
   logic [WORD_W-1:0] r_asm_data;
   logic [LANE_W-1:0] r_asm_n;
   logic              r_asm_last;
   logic              r_asm_pend;
   logic [CNT_W-1:0]  r_msg_words;

   logic              w_accept;
   logic [2:0]        w_lane;
   logic [LANE_W-1:0] w_n_inc;
   logic [WORD_W-1:0] w_merged;
   logic              w_fill_done;
   logic              w_move;
   word_t             w_new_word;
   word_t             w_slot_word;
   logic              w_slot_valid;
   logic              w_slot_can_load;
   logic              w_xfer;
   logic              w_last_xfer;
   logic              w_new_msg;

   // Only a completed word stuck behind a full OUT blocks intake.
   assign s_ready  = !r_asm_pend;
   assign w_accept = s_valid && s_ready;
   assign w_lane   = 3'd7 - r_asm_n[2:0];
   assign w_n_inc  = r_asm_n + LANE_W'(1);

   // ASM lanes below the write point are still zero, which gives the tail zero-fill.
   always_comb begin
      w_merged = r_asm_data;
      w_merged[{w_lane, 3'b000} +: BYTE_W] = s_byte;
   end

   assign w_fill_done = w_accept && (s_last || (r_asm_n == LANE_W'(BYTES_PER_WORD - 1)));
   assign w_move      = (w_fill_done || r_asm_pend) && w_slot_can_load;

   always_comb begin
      if (r_asm_pend) begin
         w_new_word = '{last: r_asm_last, inv: inv_bits(r_asm_n), data: r_asm_data};
      end else begin
         w_new_word = '{last: s_last, inv: inv_bits(w_n_inc), data: w_merged};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_asm_data <= '0;
         r_asm_n    <= '0;
         r_asm_last <= 1'b0;
         r_asm_pend <= 1'b0;
      end else if (w_move) begin
         r_asm_data <= '0;
         r_asm_n    <= '0;
         r_asm_last <= 1'b0;
         r_asm_pend <= 1'b0;
      end else if (w_accept) begin
         r_asm_data <= w_merged;
         r_asm_n    <= w_n_inc;
         r_asm_last <= s_last;
         r_asm_pend <= w_fill_done;
      end
   end

   sha_word_slot #(
      .DATA_W ($bits(word_t))
   ) u_out (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_move),
      .i_data     (w_new_word),
      .i_ready    (ready_rcv),
      .o_valid    (w_slot_valid),
      .o_data     (w_slot_word),
      .o_can_load (w_slot_can_load)
   );

   assign w_xfer      = w_slot_valid && ready_rcv;
   assign w_last_xfer = w_xfer && w_slot_word.last;

   // NOTE: defaults first so no path leaves a signal unassigned (no latch).
   always_comb begin
      w_state_nxt = r_state;
      w_new_msg   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_state_nxt = ACTIVE;
               w_new_msg   = 1'b1;
            end
         end
         ACTIVE: begin
            // Bytes already in ASM (or arriving now) belong to the next message.
            if (w_last_xfer) begin
               if (w_accept || (r_asm_n != '0)) begin
                  w_new_msg = 1'b1;
               end else begin
                  w_state_nxt = IDLE;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_msg_words <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_new_msg) begin
            r_msg_words <= '0;
         end else if (w_xfer && !(&r_msg_words)) begin
            r_msg_words <= r_msg_words + CNT_W'(1);
         end
      end
   end

   assign data_valid              = w_slot_valid;
   assign data_in                 = w_slot_word.data;
   assign last_block              = w_slot_valid && w_slot_word.last;
   assign last_block_invalid_bits = w_slot_valid ? w_slot_word.inv : '0;
   assign ready_send              = (r_state == ACTIVE) && (w_slot_valid || r_asm_pend);
   assign msg_words               = r_msg_words;

endmodule

// File: tb/tb_sha_msg_packer.sv
// Bench for sha_msg_packer: queue-based word model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic with resets.
module tb_sha_msg_packer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  s_byte = '0;
   logic        s_valid = 1'b0;
   logic        s_last = 1'b0;
   logic        ready_rcv = 1'b0;

   logic        s_ready, data_valid, ready_send, last_block;
   logic [63:0] data_in;
   logic [5:0]  inv;
   logic [15:0] msg_words;

   logic        s_ready2, data_valid2, ready_send2, last_block2;
   logic [63:0] data_in2;
   logic [5:0]  inv2;
   logic [1:0]  msg_words2;

   sha_msg_packer #(.CNT_W(16)) dut (
      .clk(clk), .rst(rst), .s_byte(s_byte), .s_valid(s_valid), .s_last(s_last),
      .s_ready(s_ready), .data_in(data_in), .data_valid(data_valid), .ready_rcv(ready_rcv),
      .ready_send(ready_send), .last_block(last_block),
      .last_block_invalid_bits(inv), .msg_words(msg_words)
   );

   sha_msg_packer #(.CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .s_byte(s_byte), .s_valid(s_valid), .s_last(s_last),
      .s_ready(s_ready2), .data_in(data_in2), .data_valid(data_valid2), .ready_rcv(ready_rcv),
      .ready_send(ready_send2), .last_block(last_block2),
      .last_block_invalid_bits(inv2), .msg_words(msg_words2)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
      end
   endtask

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   // Model: queue of completed words (front = presented word, second = stalled in ASM).
   typedef struct {
      logic [63:0] data;
      logic        last;
      int          inv;
      int          msg;
   } mword_t;

   mword_t     q[$];
   logic [7:0] part[$];
   int         acc_id, started, done;
   int         xfer[int];
   bit         m_init = 1'b0;

   function automatic int exp_words();
      int cur;
      if (started == 0) return 0;
      cur = imin(started - 1, done);
      return xfer.exists(cur) ? xfer[cur] : 0;
   endfunction

   always @(posedge clk) begin
      int     sz;
      bit     acc;
      mword_t w;
      if (rst) begin
         q.delete();
         part.delete();
         xfer.delete();
         acc_id  = 0;
         started = 0;
         done    = 0;
         m_init  = 1'b1;
      end else if (m_init) begin
         sz  = q.size();
         acc = s_valid && (sz < 2);
         if (ready_rcv && sz > 0) begin
            w = q.pop_front();
            if (!xfer.exists(w.msg)) xfer[w.msg] = 0;
            xfer[w.msg] = xfer[w.msg] + 1;
            if (w.last) done++;
         end
         if (acc) begin
            started = acc_id + 1;
            part.push_back(s_byte);
            if (part.size() == 8 || s_last) begin
               w.data = '0;
               for (int i = 0; i < part.size(); i++) w.data[63 - 8*i -: 8] = part[i];
               w.last = s_last;
               w.inv  = (8 * (8 - part.size())) % 64;
               w.msg  = acc_id;
               q.push_back(w);
               part.delete();
               if (s_last) acc_id++;
            end
         end
      end
   end

   always @(negedge clk) begin
      int sz;
      if (m_init) begin
         sz = q.size();
         check("s_ready", s_ready, sz < 2);
         check("data_valid", data_valid, sz > 0);
         check("ready_send", ready_send, sz > 0);
         check("last_block", last_block, (sz > 0) ? q[0].last : 1'b0);
         check("inv_bits", inv, (sz > 0) ? q[0].inv : 0);
         if (sz > 0) check("data_in", data_in, q[0].data);
         check("msg_words", msg_words, imin(exp_words(), 65535));
         check("msg_words_w2", msg_words2, imin(exp_words(), 3));
         check("data_valid_w2", data_valid2, sz > 0);
      end
   end

   task automatic drive(input logic v, input logic [7:0] b, input logic l,
                        input logic rr, input logic r = 1'b0);
      @(negedge clk);
      #1;
      rst = r; s_valid = v; s_byte = b; s_last = l; ready_rcv = rr;
   endtask

   task automatic idle(input logic rr);
      drive(1'b0, 8'h00, 1'b0, rr);
   endtask

   task automatic send(input logic [7:0] b, input logic l, input logic rr);
      for (int t = 0; t < 64; t++) begin
         drive(1'b1, b, l, rr);
         if (s_ready) return;
      end
      n_vec++;
      n_err++;
      $display("FAIL send_timeout at %0t: byte 0x%0h never accepted", $time, b);
   endtask

   task automatic check_reset_values();
      check("rst_s_ready", s_ready, 1'b1);
      check("rst_data_valid", data_valid, 1'b0);
      check("rst_data_in", data_in, 64'h0);
      check("rst_ready_send", ready_send, 1'b0);
      check("rst_last_block", last_block, 1'b0);
      check("rst_inv", inv, 6'd0);
      check("rst_msg_words", msg_words, 16'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog at %0t: bench did not finish", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int thr;
      repeat (2) @(negedge clk);
      check_reset_values();
      #1 rst = 1'b0;

      // 8-byte message, last on the 8th byte
      for (int i = 1; i <= 8; i++) send(8'(i), i == 8, 1'b1);
      idle(1'b1);
      check("m8_data", data_in, 64'h0102030405060708);
      check("m8_last", last_block, 1'b1);
      check("m8_inv", inv, 6'd0);
      idle(1'b0);
      check("m8_words", msg_words, 16'd1);
      check("m8_empty", data_valid, 1'b0);

      // "abc"
      send(8'h61, 1'b0, 1'b1);
      send(8'h62, 1'b0, 1'b1);
      send(8'h63, 1'b1, 1'b1);
      idle(1'b1);
      check("abc_data", data_in, 64'h6162630000000000);
      check("abc_inv", inv, 6'd40);
      check("abc_last", last_block, 1'b1);
      idle(1'b0);

      // back-pressure: 16 bytes with the core stalled
      for (int i = 0; i < 16; i++) send(8'h10 + 8'(i), 1'b0, 1'b0);
      idle(1'b0);
      check("bp_s_ready_low", s_ready, 1'b0);
      check("bp_word0", data_in, 64'h1011121314151617);
      check("bp_ready_send", ready_send, 1'b1);
      idle(1'b1);
      check("bp_word0_hold", data_in, 64'h1011121314151617);
      idle(1'b1);
      check("bp_word1", data_in, 64'h18191A1B1C1D1E1F);
      check("bp_s_ready_high", s_ready, 1'b1);
      idle(1'b0);
      check("bp_words", msg_words, 16'd2);
      check("bp_drained", data_valid, 1'b0);
      send(8'h20, 1'b1, 1'b1);
      idle(1'b1);
      idle(1'b0);

      // back-to-back messages 0xFF | 0xAA 0xBB
      send(8'hFF, 1'b1, 1'b1);
      send(8'hAA, 1'b0, 1'b1);
      check("b2b_ff", data_in, 64'hFF00000000000000);
      check("b2b_ff_inv", inv, 6'd56);
      send(8'hBB, 1'b1, 1'b1);
      check("b2b_gap_valid", data_valid, 1'b0);
      check("b2b_gap_words", msg_words, 16'd0);
      idle(1'b1);
      check("b2b_aabb", data_in, 64'hAABB000000000000);
      check("b2b_aabb_inv", inv, 6'd48);
      check("b2b_ready_send", ready_send, 1'b1);
      idle(1'b0);
      check("b2b_words", msg_words, 16'd1);

      // 40-byte message: narrow counter saturates
      for (int i = 0; i < 40; i++) send(8'(i), i == 39, 1'b1);
      idle(1'b1);
      idle(1'b1);
      idle(1'b0);
      check("sat_words16", msg_words, 16'd5);
      check("sat_words2", msg_words2, 2'd3);

      // reset mid-message, then a clean 8-byte message
      for (int i = 0; i < 5; i++) send(8'h31 + 8'(i), 1'b0, 1'b0);
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      check_reset_values();
      #1 rst = 1'b0;
      for (int i = 0; i < 8; i++) send(8'hA0 + 8'(i), i == 7, 1'b0);
      idle(1'b0);
      check("post_rst_data", data_in, 64'hA0A1A2A3A4A5A6A7);
      check("post_rst_last", last_block, 1'b1);
      idle(1'b1);
      idle(1'b0);

      // randomized traffic with varying core back-pressure and rare resets
      for (int c = 0; c < 4000; c++) begin
         thr = (c / 500) % 3 == 0 ? 2 : ((c / 500) % 3 == 1 ? 6 : 9);
         drive($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 5) == 0,
               $urandom_range(0, 9) < thr, $urandom_range(0, 999) < 3);
      end
      repeat (8) idle(1'b1);
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/sha_msg_packer.md
# sha_msg_packer

Upstream feeder for the SHA-256 core wrapper. Accepts a message as a byte stream with a valid/ready/last handshake and packs it big-endian into 64-bit words. It drives the core's `data_in`, `data_valid`, `ready_send`, `last_block` and `last_block_invalid_bits` inputs, and obeys the core's `ready_rcv`. A one-word output holding register decouples byte intake from core back-pressure.

## Interface
- `CNT_W`, 16: width of the per-message word counter; the counter saturates at all-ones.
- `clk`  in  1  single clock; everything is rising-edge.
- `rst`  in  1  reset; one clock; reset is synchronous and active-high.
- `s_byte`  in  8  message byte.
- `s_valid`  in  1  `s_byte` is valid.
- `s_last`  in  1  qualifies `s_valid`; this byte ends the message.
- `s_ready`  out  1  packer can take a byte this cycle.
- `data_in`  out  64  packed word; the first byte of the word is in [63:56].
- `data_valid`  out  1  `data_in` is valid; a word transfers on `data_valid && ready_rcv`.
- `ready_rcv`  in  1  core accepts a word this cycle.
- `ready_send`  out  1  message in flight; high from the first word presented until the last word transfers.
- `last_block`  out  1  the presented word is the final word of the message.
- `last_block_invalid_bits`  out  6  number of invalid trailing bits in the final word.
- `msg_words`  out  CNT_W  count of words transferred for the current message; holds after `last_block` until the next message starts.

## Operation
- **Assembly register** (ASM): 64-bit shift/fill register plus byte count `n`, 0..8.
  - Each accepted byte (`s_valid && s_ready`) is written at byte lane `7-n`, then `n` increments.
- **Word completion**: ASM becomes complete when `n` reaches 8, or when an accepted byte has `s_last=1`.
  - On `s_last`, lanes below the last written lane are zero-filled.
  - The `last` flag and `inv = 8*(8-n) mod 64` are latched with the word, where `n` is the number of valid bytes (1..8).
  - Resulting `inv` values: 8 bytes → 0, 1 byte → 56.
- **Output holding register** (OUT): holds word, `last` and `inv`, plus `data_valid`.
- **Transfer ASM→OUT**: occurs when ASM is complete and OUT is empty, or OUT is transferring this same cycle. ASM then clears (`n=0`).
- **Pending**: if ASM is complete and OUT cannot take it, ASM holds the word and `s_ready=0` until the move happens.
- **`s_ready` rule**: `s_ready = !(ASM complete-pending)`. It is a registered-state function only; there is no combinational path from `s_valid`.
- **State machine** (message level):
  - IDLE → ACTIVE on the first accepted byte. `msg_words` clears at that point.
  - ACTIVE → IDLE on the cycle the OUT word with `last=1` transfers.
  - `ready_send = (state==ACTIVE) && data_valid`, or ACTIVE with a word pending.
  - Bytes of the next message are accepted during the final-word handshake. They enter ASM and re-enter ACTIVE on the next cycle.
- **`msg_words`** increments on every transfer and saturates at 2^CNT_W−1.
- **Output gating**: `last_block` and `last_block_invalid_bits` are valid only while `data_valid=1` and drive 0 otherwise.
- `data_in` holds stable while `data_valid && !ready_rcv` (AXI-style: once asserted, `data_valid` never drops without a transfer).

## Timing
- **Reset values**: `s_ready=1`, `data_valid=0`, `data_in=0`, `ready_send=0`, `last_block=0`, `last_block_invalid_bits=0`, `msg_words=0`, `n=0`, state IDLE.
- **Latency**: the byte completing a word is accepted at edge t; `data_valid=1` from t+1 if OUT is free.
- **Throughput**: sustained 1 byte/cycle with zero stalls provided `ready_rcv` is high for ≥1 cycle in every 8.
- **Simultaneous events**:
  - OUT transfers while ASM completes in the same cycle → the new word loads into OUT at the same edge and `data_valid` stays high.
  - `s_last` on the 8th byte → a single word with `last=1`, `inv=0`. No extra empty word.
- **Reset mid-message**: the partial ASM and OUT contents are discarded. Outputs return to reset values on the next edge.

## Structure
- **Shared package `sha_pkg`**: `WORD_W=64`, `BYTE_W=8`, `BYTES_PER_WORD=8`, and the state encoding `IDLE`/`ACTIVE`.
- **Sub-module `sha_word_slot`**: the one-entry OUT register with valid/ready hold logic. It is reusable by a later downstream byte serializer.

## Test plan
- **8-byte message** 0x01..0x08, `s_last` on 0x08, `ready_rcv=1` → one word `data_in=0x0102030405060708`, `last_block=1`, `inv=0`, `msg_words=1`.
- **3-byte message** "abc" (0x61,0x62,0x63) → `data_in=0x6162630000000000`, `last_block=1`, `inv=40`.
- **Back-pressure**: 16 back-to-back bytes with `ready_rcv=0` → word0 holds stable in OUT, word1 fills ASM, `s_ready` falls after the 16th byte. Raising `ready_rcv` for 2 cycles transfers both words with `msg_words=2` and `s_ready` high again.
- **Back-to-back messages**: 1-byte message 0xFF then immediately a 2-byte message 0xAA,0xBB → words 0xFF00…00 (`inv=56`) and 0xAABB00…00 (`inv=48`). `msg_words` resets between them and `ready_send` drops for ≤1 cycle.
- **Saturation**: with `CNT_W=2`, a 40-byte message → `msg_words` stops at 3.
- **Reset mid-message**: assert `rst` after 5 bytes → all outputs at reset values. A following 8-byte message packs from lane 7 correctly.
